// File: rtl/vote_tally_if.sv
// Ballot-unit / readout bundle for the vote tally engine.
// The master drives ballot controls; the slave returns status and results.
interface vote_tally_if #(
    parameter int NUM_CAND = 4,
    parameter int CNT_W    = 8,
    parameter int IDX_W    = 2,
    parameter int TOT_W    = 10
);
    logic [1:0]                mode;
    logic                      arm;
    logic                      vote_valid;
    logic [NUM_CAND-1:0]       vote_in;

    logic                      armed;
    logic                      vote_accepted;
    logic                      vote_rejected;
    logic                      tally_valid;
    logic [NUM_CAND*CNT_W-1:0] count_bus;
    logic [IDX_W-1:0]          winner_idx;
    logic [CNT_W-1:0]          winner_count;
    logic                      tie;
    logic [TOT_W-1:0]          total_votes;
    logic                      overflow;

    modport master (
        output mode, arm, vote_valid, vote_in,
        input  armed, vote_accepted, vote_rejected, tally_valid,
        input  count_bus, winner_idx, winner_count, tie,
        input  total_votes, overflow
    );

    modport slave (
        input  mode, arm, vote_valid, vote_in,
        output armed, vote_accepted, vote_rejected, tally_valid,
        output count_bus, winner_idx, winner_count, tie,
        output total_votes, overflow
    );
endinterface

// File: rtl/vote_tally_engine.sv
// Multi-candidate voting engine: armed one-vote ballots, saturating
// counters and a sequential tally scan reporting winner and tie.
module vote_tally_engine #(
    parameter int NUM_CAND = 4,
    parameter int CNT_W    = 8,
    parameter int IDX_W    = 2,
    parameter int TOT_W    = 10
) (
    input logic         clk,
    input logic         reset,
    vote_tally_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ARMED, SCAN, DONE} state_t;

    localparam logic [1:0] M_CAST  = 2'b01;
    localparam logic [1:0] M_TALLY = 2'b10;
    localparam logic [1:0] M_CLEAR = 2'b11;
    localparam logic [IDX_W:0] LAST = (IDX_W+1)'(NUM_CAND);

    state_t state, state_next;

    logic [CNT_W-1:0] cnt [NUM_CAND];
    logic [TOT_W-1:0] total;
    logic             ovf;
    logic             acc_pulse;
    logic             rej_pulse;

    logic [IDX_W:0]   scan_idx;
    logic [CNT_W-1:0] max_cnt;
    logic [CNT_W-1:0] cur_cnt;
    logic [IDX_W-1:0] win;
    logic             tie_flag;

    logic one_hot;
    logic accept;
    logic reject;
    logic clear;
    logic scan_start;
    logic scan_step;
    logic done;

    always_comb begin
        one_hot = (bus.vote_in != '0) &&
                  ((bus.vote_in & (bus.vote_in - NUM_CAND'(1))) == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Mode is checked ahead of the ballot strobe so a mode change disarms.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        reject     = 1'b0;
        clear      = 1'b0;
        scan_start = 1'b0;
        scan_step  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.mode == M_CAST && bus.arm) begin
                    state_next = ARMED;
                end else if (bus.mode == M_TALLY) begin
                    state_next = SCAN;
                    scan_start = 1'b1;
                end else if (bus.mode == M_CLEAR) begin
                    clear = 1'b1;
                end
            end
            ARMED: begin
                if (bus.mode != M_CAST) begin
                    state_next = IDLE;
                end else if (bus.vote_valid) begin
                    if (one_hot) begin
                        accept     = 1'b1;
                        state_next = IDLE;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (bus.mode != M_TALLY) state_next = IDLE;
                else if (scan_idx == LAST) state_next = DONE;
                else scan_step = 1'b1;
            end
            DONE: begin
                if (bus.mode != M_TALLY) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cur_cnt = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (scan_idx == (IDX_W+1)'(i)) cur_cnt = cnt[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CAND; i++) cnt[i] <= '0;
            total     <= '0;
            ovf       <= 1'b0;
            acc_pulse <= 1'b0;
            rej_pulse <= 1'b0;
            scan_idx  <= '0;
            max_cnt   <= '0;
            win       <= '0;
            tie_flag  <= 1'b0;
        end else begin
            acc_pulse <= accept;
            rej_pulse <= reject;
            if (clear) begin
                for (int i = 0; i < NUM_CAND; i++) cnt[i] <= '0;
                total <= '0;
                ovf   <= 1'b0;
            end else if (accept) begin
                for (int i = 0; i < NUM_CAND; i++) begin
                    if (bus.vote_in[i]) begin
                        if (&cnt[i]) ovf <= 1'b1;
                        else cnt[i] <= cnt[i] + CNT_W'(1);
                    end
                end
                if (&total) ovf <= 1'b1;
                else total <= total + TOT_W'(1);
            end
            // Strict greater-than keeps the lowest index on equal counts.
            if (scan_start) begin
                scan_idx <= '0;
                max_cnt  <= '0;
                win      <= '0;
                tie_flag <= 1'b0;
            end else if (scan_step) begin
                scan_idx <= scan_idx + (IDX_W+1)'(1);
                if (cur_cnt > max_cnt) begin
                    max_cnt  <= cur_cnt;
                    win      <= scan_idx[IDX_W-1:0];
                    tie_flag <= 1'b0;
                end else if (cur_cnt == max_cnt && scan_idx != '0) begin
                    tie_flag <= 1'b1;
                end
            end
        end
    end

    assign done = (state == DONE);

    always_comb begin
        bus.count_bus = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            bus.count_bus[i*CNT_W +: CNT_W] = done ? cnt[i] : '0;
        end
    end

    assign bus.armed         = (state == ARMED);
    assign bus.tally_valid   = done;
    assign bus.winner_idx    = done ? win : '0;
    assign bus.winner_count  = done ? max_cnt : '0;
    assign bus.tie           = done & tie_flag;
    assign bus.vote_accepted = acc_pulse;
    assign bus.vote_rejected = rej_pulse;
    assign bus.total_votes   = total;
    assign bus.overflow      = ovf;
endmodule

// File: tb/tb_vote_tally_engine.sv
// Directed bench for vote_tally_engine with hand-computed expectations.
// Inputs change 1ns after each rising edge; outputs are checked there too.
module tb_vote_tally_engine;
    localparam int NUM_CAND = 4;
    localparam int CNT_W    = 8;
    localparam int IDX_W    = 2;
    localparam int TOT_W    = 10;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    vote_tally_if #(
        .NUM_CAND(NUM_CAND), .CNT_W(CNT_W),
        .IDX_W(IDX_W), .TOT_W(TOT_W)
    ) bus ();

    vote_tally_engine #(
        .NUM_CAND(NUM_CAND), .CNT_W(CNT_W),
        .IDX_W(IDX_W), .TOT_W(TOT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cast(input logic [3:0] v);
        bus.mode = 2'b01;
        bus.arm  = 1'b1;
        tick();
        bus.arm        = 1'b0;
        bus.vote_valid = 1'b1;
        bus.vote_in    = v;
        tick();
        bus.vote_valid = 1'b0;
        chk("cast_accept", bus.vote_accepted, 1);
    endtask

    // Run a tally to DONE: e0 plus NUM_CAND+1 more edges.
    task automatic tally();
        bus.mode = 2'b10;
        tick();
        repeat (NUM_CAND) tick();
        chk("tally_early", bus.tally_valid, 0);
        tick();
        chk("tally_valid", bus.tally_valid, 1);
    endtask

    task automatic to_idle_clear();
        bus.mode = 2'b00;
        tick();
        bus.mode = 2'b11;
        tick();
        bus.mode = 2'b00;
    endtask

    initial begin
        reset          = 1'b1;
        bus.mode       = 2'b00;
        bus.arm        = 1'b0;
        bus.vote_valid = 1'b0;
        bus.vote_in    = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("rst_armed", bus.armed, 0);
        chk("rst_total", bus.total_votes, 0);
        chk("rst_tv", bus.tally_valid, 0);
        chk("rst_ovf", bus.overflow, 0);
        chk("rst_bus", bus.count_bus, 0);

        // single vote for candidate 2 then tally
        bus.mode = 2'b01;
        bus.arm  = 1'b1;
        tick();
        bus.arm = 1'b0;
        chk("armed_up", bus.armed, 1);
        bus.vote_valid = 1'b1;
        bus.vote_in    = 4'b0100;
        tick();
        bus.vote_valid = 1'b0;
        chk("acc_pulse", bus.vote_accepted, 1);
        chk("acc_total", bus.total_votes, 1);
        chk("acc_disarm", bus.armed, 0);
        tick();
        chk("acc_pulse_end", bus.vote_accepted, 0);
        tally();
        chk("t1_bus", bus.count_bus, 32'h0001_0000);
        chk("t1_win", bus.winner_idx, 2);
        chk("t1_wcnt", bus.winner_count, 1);
        chk("t1_tie", bus.tie, 0);
        bus.mode = 2'b00;
        tick();
        chk("t1_leave", bus.tally_valid, 0);
        chk("t1_bus_hidden", bus.count_bus, 0);

        // malformed ballots
        bus.mode = 2'b01;
        bus.arm  = 1'b1;
        tick();
        bus.arm        = 1'b0;
        bus.vote_valid = 1'b1;
        bus.vote_in    = 4'b0110;
        tick();
        chk("rej_multi", bus.vote_rejected, 1);
        chk("rej_armed", bus.armed, 1);
        bus.vote_in = 4'b0000;
        tick();
        chk("rej_zero", bus.vote_rejected, 1);
        bus.vote_valid = 1'b0;
        tick();
        chk("rej_end", bus.vote_rejected, 0);
        chk("rej_total", bus.total_votes, 1);
        chk("rej_still_armed", bus.armed, 1);
        bus.vote_valid = 1'b1;
        bus.vote_in    = 4'b0001;
        tick();
        chk("rej_then_acc", bus.vote_accepted, 1);
        chk("rej_acc_total", bus.total_votes, 2);

        // second strobe without re-arm is ignored
        bus.vote_valid = 1'b0;
        cast(4'b0010);
        bus.vote_valid = 1'b1;
        tick();
        bus.vote_valid = 1'b0;
        chk("dbl_acc", bus.vote_accepted, 0);
        chk("dbl_rej", bus.vote_rejected, 0);
        chk("dbl_total", bus.total_votes, 3);
        bus.mode = 2'b00;
        tick();
        tally();
        chk("t2_bus", bus.count_bus, 32'h0001_0101);
        chk("t2_win", bus.winner_idx, 0);
        chk("t2_wcnt", bus.winner_count, 1);
        chk("t2_tie", bus.tie, 1);

        // mode leaves cast while armed: no vote recorded
        bus.mode = 2'b00;
        tick();
        bus.mode = 2'b01;
        bus.arm  = 1'b1;
        tick();
        bus.arm        = 1'b0;
        bus.mode       = 2'b00;
        bus.vote_valid = 1'b1;
        bus.vote_in    = 4'b0001;
        tick();
        bus.vote_valid = 1'b0;
        chk("mode_drop_acc", bus.vote_accepted, 0);
        chk("mode_drop_arm", bus.armed, 0);
        chk("mode_drop_tot", bus.total_votes, 3);

        to_idle_clear();
        chk("clr_total", bus.total_votes, 0);

        // 3x cand1, 3x cand3, 1x cand0
        cast(4'b0010);
        cast(4'b1000);
        cast(4'b0010);
        cast(4'b1000);
        cast(4'b0001);
        cast(4'b0010);
        cast(4'b1000);
        bus.mode = 2'b00;
        tick();
        tally();
        chk("t3_bus", bus.count_bus, 32'h0300_0301);
        chk("t3_win", bus.winner_idx, 1);
        chk("t3_wcnt", bus.winner_count, 3);
        chk("t3_tie", bus.tie, 1);
        chk("t3_total", bus.total_votes, 7);

        // saturation of candidate 0
        to_idle_clear();
        for (int k = 0; k < 255; k++) cast(4'b0001);
        chk("sat_pre_ovf", bus.overflow, 0);
        cast(4'b0001);
        chk("sat_ovf", bus.overflow, 1);
        chk("sat_total", bus.total_votes, 256);
        bus.mode = 2'b00;
        tick();
        tally();
        chk("sat_cnt0", bus.count_bus, 32'h0000_00ff);
        chk("sat_wcnt", bus.winner_count, 255);
        to_idle_clear();
        chk("sat_clr_total", bus.total_votes, 0);
        chk("sat_clr_ovf", bus.overflow, 0);
        tally();
        chk("zero_bus", bus.count_bus, 0);
        chk("zero_win", bus.winner_idx, 0);
        chk("zero_wcnt", bus.winner_count, 0);
        chk("zero_tie", bus.tie, 1);

        // aborted scan
        bus.mode = 2'b00;
        tick();
        bus.mode = 2'b10;
        tick();
        tick();
        bus.mode = 2'b00;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("abort_tv", bus.tally_valid, 0);
        end
        bus.mode = 2'b01;
        bus.arm  = 1'b1;
        tick();
        bus.arm = 1'b0;
        chk("abort_idle", bus.armed, 1);

        // reset while armed
        bus.mode = 2'b00;
        tick();
        cast(4'b0100);
        chk("pre_rst_total", bus.total_votes, 1);
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
        chk("pre_rst_armed", bus.armed, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst2_armed", bus.armed, 0);
        chk("rst2_total", bus.total_votes, 0);
        bus.mode = 2'b00;
        tick();
        tally();
        chk("rst2_bus", bus.count_bus, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
